// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl shared types: FSM states, opcode/funct constants and the
// control vector bundle driven by mc_ctrl_decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_ADDR,
    S_MEM_RD,
    S_WB_LD,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] F_JR     = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL};
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State -> control vector for mc_ctrl (combinational).
// Ports: state, opcode, mem_ready in; ctrl out. Macro: MC_ILLEGAL_TRAP_EN.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
`ifndef MC_ILLEGAL_TRAP_EN
        // unknown opcode retires here as a NOP
        ctrl.retire    = !op_known(opcode);
`endif
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 2'b01;
        ctrl.retire    = 1'b1;
      end
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_WB_LD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 2'b01;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 2'b01;
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'b10;
        ctrl.retire   = 1'b1;
        if (opcode == OP_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 2'b10;
          ctrl.mem_to_reg = 2'b10;
        end
      end
      S_JR: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'b11;
        ctrl.retire   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register + next-state logic.
// Ports: clk, rst_n, opcode, funct, zero, mem_ready in; datapath
// enables/selects, retire, illegal out. Macro: MC_ILLEGAL_TRAP_EN.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int RA_IDX = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal
);

  if (RA_IDX < 0 || RA_IDX > 31) begin : g_bad_ra
    $error("RA_IDX must be a 5-bit register index");
  end

  // zero qualifies pc_write_cond in the datapath, not here
  logic unused_zero;
  assign unused_zero = zero;

  state_t state;
  ctrl_t  ctrl;

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:
              state <= (funct == F_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW: state <= S_ADDR;
            OP_BEQ:       state <= S_BRANCH;
            OP_J, OP_JAL: state <= S_JUMP;
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
              state     <= S_HALT;
              illegal_q <= 1'b1;
`else
              state <= S_FETCH;
`endif
            end
          endcase
        end
        S_EXEC_R: state <= S_WB_R;
        S_ADDR:
          state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (mem_ready) state <= S_WB_LD;
        S_MEM_WR: if (mem_ready) state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign retire        = ctrl.retire;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: random instruction stream with
// random memory stalls against a per-instruction cycle-table model.
module tb_mc_ctrl;

  typedef enum int {
    K_R, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_BAD
  } kind_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read;
  logic       mem_write, ir_write, reg_write, alu_src_a;
  logic       retire, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic [18:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
    .illegal(illegal)
  );

  assign obs = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read,
                mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, retire};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // f = fetch stall cycles, m = data-memory stall cycles
  function automatic int total_cycles(kind_t k, int f, int m);
    case (k)
      K_R:     return f + 4;
      K_LW:    return f + 5 + m;
      K_SW:    return f + 4 + m;
`ifdef MC_ILLEGAL_TRAP_EN
      K_BAD:   return f + 7;
`else
      K_BAD:   return f + 2;
`endif
      default: return f + 3;
    endcase
  endfunction

  // expected control vector in cycle c of an instruction
  function automatic logic [18:0] exp_ctrl(kind_t k, int c,
                                           int f, int m);
    logic pw, pwc, iod, mr, mw, irw, rw, sa, ret;
    logic [1:0] ps, rd, m2r, sb, op;
    int d;
    {pw, pwc, iod, mr, mw, irw, rw, sa, ret} = '0;
    {ps, rd, m2r, sb, op} = '0;
    d = c - f - 2;
    if (c <= f) begin
      mr = 1; sb = 2'b01;
      if (c == f) begin irw = 1; pw = 1; end
    end else if (c == f + 1) begin
      sb = 2'b11;
`ifndef MC_ILLEGAL_TRAP_EN
      if (k == K_BAD) ret = 1;
`endif
    end else begin
      case (k)
        K_R:
          if (d == 0) begin sa = 1; op = 2'b10; end
          else begin rw = 1; rd = 2'b01; ret = 1; end
        K_LW:
          if (d == 0) begin sa = 1; sb = 2'b10; end
          else if (d <= 1 + m) begin mr = 1; iod = 1; end
          else begin rw = 1; m2r = 2'b01; ret = 1; end
        K_SW:
          if (d == 0) begin sa = 1; sb = 2'b10; end
          else begin mw = 1; iod = 1; ret = (d == 1 + m); end
        K_BEQ: begin
          sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; ret = 1;
        end
        K_J, K_JAL: begin
          pw = 1; ps = 2'b10; ret = 1;
          if (k == K_JAL) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
        end
        K_JR: begin pw = 1; ps = 2'b11; ret = 1; end
        default: ;
      endcase
    end
    return {pw, pwc, ps, iod, mr, mw, irw, rw, rd, m2r, sa, sb, op, ret};
  endfunction

  function automatic logic [5:0] op_of(kind_t k);
    logic [5:0] o;
    case (k)
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_BEQ:   return 6'b000100;
      K_J:     return 6'b000010;
      K_JAL:   return 6'b000011;
      K_BAD: begin
        do o = 6'($urandom);
        while (o inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd35, 6'd43});
        return o;
      end
      default: return 6'b000000;
    endcase
  endfunction

  // starts and ends at posedge+1; samples at posedge+5
  task automatic run_instr(kind_t k, logic [5:0] op, logic [5:0] fn,
                           int f, int m);
    int  n = total_cycles(k, f, m);
    bit  mem_k = (k == K_LW || k == K_SW);
    for (int c = 0; c < n; c++) begin
      opcode = (c <= f) ? 6'($urandom) : op;
      funct  = (c <= f) ? 6'($urandom) : fn;
      zero   = 1'($urandom);
      if (c < f) mem_ready = 0;
      else if (c == f) mem_ready = 1;
      else if (mem_k && c >= f + 3 && c < f + 3 + m) mem_ready = 0;
      else if (mem_k && c == f + 3 + m) mem_ready = 1;
      else mem_ready = 1'($urandom);
      #4;
      check($sformatf("%s op%0h c%0d ctrl", k.name(), op, c),
            obs, exp_ctrl(k, c, f, m));
`ifdef MC_ILLEGAL_TRAP_EN
      check($sformatf("%s c%0d illegal", k.name(), c), illegal,
            (k == K_BAD && c >= f + 2));
`else
      check($sformatf("%s c%0d illegal", k.name(), c), illegal, 0);
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    mem_ready = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    kind_t k;
    logic [5:0] fn;
    rst_n = 0; opcode = 0; funct = 0; zero = 0; mem_ready = 0;
    @(posedge clk); #1;
    check("reset ctrl", obs, exp_ctrl(K_R, 0, 1, 0));
    check("reset illegal", illegal, 0);
    rst_n = 1;

    run_instr(K_R, 6'b000000, 6'b100000, 0, 0);
    run_instr(K_LW, op_of(K_LW), 6'd0, 0, 2);
    run_instr(K_SW, op_of(K_SW), 6'd0, 1, 1);
    run_instr(K_BEQ, op_of(K_BEQ), 6'd0, 0, 0);
    run_instr(K_BEQ, op_of(K_BEQ), 6'd0, 2, 0);
    run_instr(K_JAL, op_of(K_JAL), 6'd0, 0, 0);
    run_instr(K_J, op_of(K_J), 6'd0, 1, 0);
    run_instr(K_JR, 6'b000000, 6'b001000, 0, 0);

    // reset while sw waits in MEM_WR
    opcode = op_of(K_SW); funct = 0; mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #4;
    check("sw mem_write", mem_write, 1);
    rst_n = 0;
    #1;
    check("async rst ctrl", obs, exp_ctrl(K_R, 0, 1, 0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    run_instr(K_R, 6'b000000, 6'b100010, 1, 0);

    for (int i = 0; i < 80; i++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      k = kind_t'($urandom_range(0, 6));
`else
      k = kind_t'($urandom_range(0, 7));
`endif
      fn = 6'($urandom);
      if (k == K_R && fn == 6'b001000) fn = 6'b100000;
      if (k == K_JR) fn = 6'b001000;
      run_instr(k, op_of(k), fn, $urandom_range(0, 3),
                $urandom_range(0, 3));
    end

    run_instr(K_BAD, 6'b111111, 6'd0, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    pulse_reset();
    check("halt cleared", illegal, 0);
`endif
    run_instr(K_LW, op_of(K_LW), 6'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
